// File: rtl/vpu_ub_writer.sv
// rtl/vpu_ub_writer.sv - VPU lane results buffered per lane and serialised into unified-buffer writes.
// Optional macro VPU_UB_WRITER_PERF_EN adds the ub_stall_cycles output.
module vpu_ub_writer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [DATA_W-1:0] lane_data_1,
  input  logic [DATA_W-1:0] lane_data_2,
  input  logic              lane_valid_1,
  input  logic              lane_valid_2,
  output logic              ub_wr_en,
  output logic [ADDR_W-1:0] ub_wr_addr,
  output logic [DATA_W-1:0] ub_wr_data,
  input  logic              ub_wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef VPU_UB_WRITER_PERF_EN
  ,
  output logic [15:0]       ub_stall_cycles
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, rows_q;
  logic [ADDR_W-1:0] row_q  [2];
  logic [ADDR_W-1:0] row_d  [2];
  logic [PW:0]       wptr_q [2];
  logic [PW:0]       rptr_q [2];
  logic [EW-1:0]     mem_q  [2][FIFO_DEPTH];
  logic [EW-1:0]     tag    [2];
  logic [DATA_W-1:0] ldata  [2];
  logic              overflow_q, prio_q, hold_q, hold_lane_q;
  logic [1:0]        valid, cap, push, pop, ne, full, last;
  logic              active, launch, grant, xfer, drop;
  logic [EW-1:0]     head;

  always_comb begin
    ldata[0] = lane_data_1;
    ldata[1] = lane_data_2;
    valid    = {lane_valid_2, lane_valid_1};
    active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    launch   = (state_q == S_IDLE) && start;
    for (int l = 0; l < 2; l++) begin
      ne[l]    = wptr_q[l] != rptr_q[l];
      full[l]  = (wptr_q[l][PW] != rptr_q[l][PW]) && (wptr_q[l][PW-1:0] == rptr_q[l][PW-1:0]);
      cap[l]   = (state_q == S_RUN) && valid[l] && (row_q[l] != rows_q);
      row_d[l] = row_q[l] + ADDR_W'(cap[l]);
      // Lane l of row r lands at base + 2r + l; the sum wraps naturally at ADDR_W bits.
      tag[l]   = {base_q + {row_q[l][ADDR_W-2:0], 1'b0} + ADDR_W'(l), ldata[l]};
    end
    ub_wr_en = active && (|ne);
    // A stalled request keeps its lane so address/data cannot change under the consumer.
    if (hold_q)     grant = hold_lane_q;
    else if (&ne)   grant = prio_q;
    else            grant = !ne[0];
    xfer        = ub_wr_en && ub_wr_ready;
    pop         = '0;
    pop[grant]  = xfer;
    push        = cap & (~full | pop);
    drop        = |(cap & full & ~pop);
    head        = mem_q[grant][rptr_q[grant][PW-1:0]];
    ub_wr_addr  = ub_wr_en ? head[EW-1:DATA_W] : '0;
    ub_wr_data  = ub_wr_en ? head[DATA_W-1:0] : '0;
    for (int l = 0; l < 2; l++) begin
      last[l] = (wptr_q[l] - rptr_q[l]) == (PW+1)'(pop[l]);
    end
    busy     = active;
    done     = state_q == S_DONE;
    overflow = overflow_q;

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = (num_rows == '0) ? S_DONE : S_RUN;
      S_RUN:   if (row_d[0] == rows_q && row_d[1] == rows_q) state_d = S_DRAIN;
      S_DRAIN: if (&last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      rows_q      <= '0;
      overflow_q  <= 1'b0;
      prio_q      <= 1'b0;
      hold_q      <= 1'b0;
      hold_lane_q <= 1'b0;
      for (int l = 0; l < 2; l++) begin
        row_q[l]  <= '0;
        wptr_q[l] <= '0;
        rptr_q[l] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hold_q      <= ub_wr_en && !ub_wr_ready;
      hold_lane_q <= grant;
      if (xfer) prio_q <= ~grant;
      if (launch) begin
        base_q     <= base_addr;
        rows_q     <= num_rows;
        overflow_q <= 1'b0;
        for (int l = 0; l < 2; l++) begin
          row_q[l]  <= '0;
          wptr_q[l] <= '0;
          rptr_q[l] <= '0;
        end
      end else begin
        if (drop) overflow_q <= 1'b1;
        for (int l = 0; l < 2; l++) begin
          row_q[l]  <= row_d[l];
          wptr_q[l] <= wptr_q[l] + (PW+1)'(push[l]);
          rptr_q[l] <= rptr_q[l] + (PW+1)'(pop[l]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (push[l]) mem_q[l][wptr_q[l][PW-1:0]] <= tag[l];
    end
  end

`ifdef VPU_UB_WRITER_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (launch) begin
      stall_q <= '0;
    end else if (active && ub_wr_en && !ub_wr_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign ub_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vpu_ub_writer.sv
// tb/tb_vpu_ub_writer.sv - self-checking bench for vpu_ub_writer against a queue-level model.
module tb_vpu_ub_writer;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0, num_rows = '0;
  logic [DW-1:0] lane_data_1 = '0, lane_data_2 = '0;
  logic          lane_valid_1 = 1'b0, lane_valid_2 = 1'b0;
  logic          ub_wr_ready = 1'b1;
  logic          ub_wr_en, busy, done, overflow;
  logic [AW-1:0] ub_wr_addr;
  logic [DW-1:0] ub_wr_data;
`ifdef VPU_UB_WRITER_PERF_EN
  logic [15:0]   ub_stall_cycles;
`endif

  always #5 clk = ~clk;

  vpu_ub_writer #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .lane_data_1(lane_data_1), .lane_data_2(lane_data_2),
    .lane_valid_1(lane_valid_1), .lane_valid_2(lane_valid_2),
    .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
    .ub_wr_ready(ub_wr_ready), .busy(busy), .done(done), .overflow(overflow)
`ifdef VPU_UB_WRITER_PERF_EN
    , .ub_stall_cycles(ub_stall_cycles)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;
  logic [AW+DW-1:0] wlog[$];

  // Model: per-lane queues of {addr,data}, round-robin with a held grant while stalled.
  int m_mode = M_IDLE;
  logic [AW+DW-1:0] q1[$], q2[$];
  int m_cnt1 = 0, m_cnt2 = 0, m_rows = 0, m_base = 0;
  int m_last = 2;
  bit m_held = 1'b0;
  int m_held_lane = 1;
  bit m_ovf = 1'b0;
  int m_stall = 0;

  function automatic bit m_en();
    return (m_mode == M_RUN || m_mode == M_DRAIN) && (q1.size() != 0 || q2.size() != 0);
  endfunction

  function automatic int m_grant();
    if (m_held) return m_held_lane;
    if (q1.size() != 0 && q2.size() != 0) return (m_last == 1) ? 2 : 1;
    return (q1.size() != 0) ? 1 : 2;
  endfunction

  task automatic model_step();
    bit en;
    int g;
    logic [AW-1:0] a;
    if (rst) begin
      m_mode = M_IDLE; q1.delete(); q2.delete(); m_cnt1 = 0; m_cnt2 = 0;
      m_rows = 0; m_base = 0; m_last = 2; m_held = 1'b0; m_ovf = 1'b0; m_stall = 0;
      return;
    end
    en = m_en();
    g  = m_grant();
    if (en && !ub_wr_ready && m_stall < 65535) m_stall++;
    if (en && ub_wr_ready) begin
      if (g == 1) void'(q1.pop_front()); else void'(q2.pop_front());
      m_last = g;
      m_held = 1'b0;
    end else begin
      m_held = en;
      m_held_lane = g;
    end
    case (m_mode)
      M_IDLE: if (start) begin
        m_base = int'(base_addr); m_rows = int'(num_rows);
        m_cnt1 = 0; m_cnt2 = 0; q1.delete(); q2.delete(); m_ovf = 1'b0; m_stall = 0;
        m_mode = (m_rows == 0) ? M_DONE : M_RUN;
      end
      M_RUN: begin
        if (lane_valid_1 && m_cnt1 != m_rows) begin
          a = AW'(m_base + 2 * m_cnt1);
          if (q1.size() < DEPTH) q1.push_back({a, lane_data_1}); else m_ovf = 1'b1;
          m_cnt1++;
        end
        if (lane_valid_2 && m_cnt2 != m_rows) begin
          a = AW'(m_base + 2 * m_cnt2 + 1);
          if (q2.size() < DEPTH) q2.push_back({a, lane_data_2}); else m_ovf = 1'b1;
          m_cnt2++;
        end
        if (m_cnt1 == m_rows && m_cnt2 == m_rows) m_mode = M_DRAIN;
      end
      M_DRAIN: if (q1.size() == 0 && q2.size() == 0) m_mode = M_DONE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit en;
      int g;
      logic [AW+DW-1:0] h;
      en = m_en();
      g  = m_grant();
      h  = '0;
      if (en) h = (g == 1) ? q1[0] : q2[0];
      check("wr_en", ub_wr_en, en);
      check("wr_addr", ub_wr_addr, h[AW+DW-1:DW]);
      check("wr_data", ub_wr_data, h[DW-1:0]);
      check("busy", busy, (m_mode == M_RUN || m_mode == M_DRAIN));
      check("done", done, (m_mode == M_DONE));
      check("overflow", overflow, m_ovf);
`ifdef VPU_UB_WRITER_PERF_EN
      check("stall_cycles", ub_stall_cycles, m_stall);
`endif
      if (ub_wr_en === 1'b1 && ub_wr_ready) wlog.push_back({ub_wr_addr, ub_wr_data});
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic new_test();
    wlog.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input int base, input int rows);
    base_addr = AW'(base);
    num_rows  = AW'(rows);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input bit v1, input int d1, input bit v2, input int d2, input bit rdy);
    lane_valid_1 = v1; lane_data_1 = DW'(d1);
    lane_valid_2 = v2; lane_data_2 = DW'(d2);
    ub_wr_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done_cnt == 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_done_seen"}, (done_cnt != 0), 1);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, done_cnt, 1);
  endtask

  // Writes are expected at consecutive addresses, alternating lane 1 / lane 2 data.
  task automatic check_writes(input string name, input int n, input int base,
                              input int d1, input int d2, input int s);
    check({name, "_count"}, wlog.size(), n);
    for (int i = 0; i < n && i < wlog.size(); i++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ea = AW'(base + i);
      ed = DW'((i % 2 == 0) ? d1 + s * (i / 2) : d2 + s * (i / 2));
      check($sformatf("%s_addr%0d", name, i), wlog[i][AW+DW-1:DW], ea);
      check($sformatf("%s_data%0d", name, i), wlog[i][DW-1:0], ed);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", ub_wr_en, 0);
    check("rst_addr", ub_wr_addr, 0);
    check("rst_data", ub_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 1);

    new_test();
    do_start(8'h10, 3);
    for (int k = 0; k < 3; k++) drive(1, 2 * k + 1, 1, 2 * k + 2, 1);
    drive(0, 0, 0, 0, 1);
    wait_done("basic");
    check_writes("basic", 6, 8'h10, 1, 2, 2);
    check("basic_ovf", overflow, 0);

    new_test();
    do_start(8'h20, 4);
    for (int k = 0; k < 5; k++) drive(k < 4, 16'h100 + k, k >= 1, 16'h200 + k - 1, 1);
    wait_done("skew");
    check_writes("skew", 8, 8'h20, 16'h100, 16'h200, 1);

    new_test();
    do_start(8'h40, 4);
    for (int k = 0; k < 6; k++) drive(k < 4, 16'h300 + k, k < 4, 16'h400 + k, !(k >= 2 && k <= 4));
    wait_done("bp");
    check_writes("bp", 8, 8'h40, 16'h300, 16'h400, 1);
    check("bp_ovf", overflow, 0);
`ifdef VPU_UB_WRITER_PERF_EN
    check("bp_stalls", ub_stall_cycles, 3);
`endif

    new_test();
    do_start(8'h60, 6);
    for (int k = 0; k < 8; k++) drive(k < 6, 16'h500 + k, k < 6, 16'h600 + k, 0);
    check("ovf_set", overflow, 1);
    ub_wr_ready = 1'b1;
    wait_done("ovf");
    check_writes("ovf", 8, 8'h60, 16'h500, 16'h600, 1);
    check("ovf_sticky", overflow, 1);
`ifdef VPU_UB_WRITER_PERF_EN
    check("ovf_stalls", ub_stall_cycles, 7);
`endif

    new_test();
    do_start(8'h33, 0);
    check("zero_done_now", done, 1);
    check("zero_busy", busy, 0);
    wait_done("zero");
    check("zero_writes", wlog.size(), 0);

    new_test();
    do_start(8'hFE, 2);
    for (int k = 0; k < 2; k++) drive(1, 16'h700 + k, 1, 16'h800 + k, 1);
    drive(0, 0, 0, 0, 1);
    wait_done("wrap");
    check_writes("wrap", 4, 8'hFE, 16'h700, 16'h800, 1);

    new_test();
    do_start(8'h80, 4);
    for (int k = 0; k < 6; k++) drive(k < 4, 16'hA00 + k, k < 4, 16'hB00 + k, 0);
    check("drain_busy", busy, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", ub_wr_en, 0);
    check("mid_rst_addr", ub_wr_addr, 0);
    check("mid_rst_data", ub_wr_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_no_writes", wlog.size(), 0);

    new_test();
    do_start(8'h90, 1);
    drive(1, 16'h900, 1, 16'h901, 1);
    drive(0, 0, 0, 0, 1);
    wait_done("after_rst");
    check_writes("after_rst", 2, 8'h90, 16'h900, 16'h901, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
